histogram_reader: RTL and testbench

- Readout engine on the histogram RAM's read port B: the reader paired with the pixel-counting histogram writer.
- On `start`, sweeps bins 0..COLOR_RANGE-1 and captures each count.
- Builds the running cumulative sum (CDF) and streams (bin, count, cdf) triples over a valid/ready interface.
- Feeds the equalisation LUT builder; sits between the histogram block and downstream frame-level statistics.

---
 rtl/histogram_reader_if.sv | 30 +++
 rtl/histogram_reader.sv | 182 ++++++++++++++++++
 tb/tb_histogram_reader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/histogram_reader_if.sv
// Port bundle for histogram_reader: histogram RAM read port B plus the (bin, count, cdf) output stream.
// master = the reader, slave = the histogram RAM / downstream consumer side.
interface histogram_reader_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 19,
    parameter int CDF_WIDTH     = 19
);
    logic [ADDRESS_WIDTH-1:0] hist_addr;
    logic                     hist_rreq;
    logic [DATA_WIDTH-1:0]    hist_data;
    logic                     hist_dvalid;
    logic                     hist_clear;
    logic [ADDRESS_WIDTH-1:0] out_bin;
    logic [DATA_WIDTH-1:0]    out_count;
    logic [CDF_WIDTH-1:0]     out_cdf;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output hist_addr, hist_rreq, hist_clear,
        output out_bin, out_count, out_cdf, out_valid,
        input  hist_data, hist_dvalid, out_ready
    );

    modport slave (
        input  hist_addr, hist_rreq, hist_clear,
        input  out_bin, out_count, out_cdf, out_valid,
        output hist_data, hist_dvalid, out_ready
    );
endinterface

// File: rtl/histogram_reader.sv
// Histogram readout engine: sweeps every bin over RAM port B and streams (bin, count, cdf) beats.
// Macro HIST_AUTO_CLEAR_EN adds a CLR state that pulses hist_clear once before done.
module histogram_reader #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int COLOR_RANGE  = 256,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic               start,
    output logic               busy,
    output logic               done,
    histogram_reader_if.master bus
);
    function automatic int clogb2(input longint value);
        int bits;
        bits = 32'sd1;
        for (int i = 32'sd1; i < 32'sd62; i++) begin
            if ((64'sd1 <<< i) <= value) bits = i + 32'sd1;
        end
        return bits;
    endfunction

    localparam int AW    = clogb2(longint'(COLOR_RANGE) - 64'sd1);
    localparam int DW    = clogb2(longint'(IMAGE_WIDTH) * longint'(IMAGE_HEIGHT) - 64'sd1);
    localparam int CW    = clogb2(longint'(IMAGE_WIDTH) * longint'(IMAGE_HEIGHT));
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 32'sd1;
    localparam int SUM_W = CNT_W + 32'sd1;

    if (PIXEL_WIDTH < 32'sd1 || FIFO_DEPTH < 32'sd2 || (FIFO_DEPTH & (FIFO_DEPTH - 32'sd1)) != 32'sd0) begin : g_bad_param
        $error("histogram_reader: PIXEL_WIDTH must be >= 1 and FIFO_DEPTH a power of two >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SWEEP = 3'd1,
        ST_DRAIN = 3'd2,
`ifdef HIST_AUTO_CLEAR_EN
        ST_CLR   = 3'd3,
`endif
        ST_FIN   = 3'd4
    } state_t;

    typedef struct packed {
        logic [AW-1:0] bin;
        logic [DW-1:0] count;
        logic [CW-1:0] cdf;
    } beat_t;

    state_t           state_r, state_s;
    logic [AW-1:0]    rd_addr_r, ret_bin_r;
    logic [CW-1:0]    cdf_acc_r, cdf_sum_s;
    logic [CNT_W-1:0] outstanding_r, fifo_count_r;
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    beat_t            fifo_mem_r [FIFO_DEPTH];
    beat_t            head_s;
    logic             credit_s, last_addr_s, issue_s, accept_s, pop_s, active_s;

    // Credit rule: reads in flight plus buffered beats never exceed the FIFO, so a return always has a slot.
    assign credit_s    = ({1'b0, outstanding_r} + {1'b0, fifo_count_r}) < SUM_W'(FIFO_DEPTH);
    assign active_s    = (state_r == ST_SWEEP) || (state_r == ST_DRAIN);
    assign last_addr_s = (rd_addr_r == AW'(COLOR_RANGE - 32'sd1));
    assign issue_s     = (state_r == ST_SWEEP) && credit_s;
    assign accept_s    = active_s && bus.hist_dvalid;
    assign pop_s       = (fifo_count_r != '0) && bus.out_ready;
    assign cdf_sum_s   = cdf_acc_r + CW'(bus.hist_data);
    assign head_s      = fifo_mem_r[rd_ptr_r];

    assign bus.out_valid = (fifo_count_r != '0);
    assign bus.out_bin   = head_s.bin;
    assign bus.out_count = head_s.count;
    assign bus.out_cdf   = head_s.cdf;

    // FSM state register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (start) state_s = ST_SWEEP; else state_s = ST_IDLE;
            ST_SWEEP: if (issue_s && last_addr_s) state_s = ST_DRAIN; else state_s = ST_SWEEP;
            ST_DRAIN: begin
                if (outstanding_r == '0 && fifo_count_r == '0) begin
`ifdef HIST_AUTO_CLEAR_EN
                    state_s = ST_CLR;
`else
                    state_s = ST_FIN;
`endif
                end else begin
                    state_s = ST_DRAIN;
                end
            end
`ifdef HIST_AUTO_CLEAR_EN
            ST_CLR:   state_s = ST_FIN;
`endif
            ST_FIN:   state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        bus.hist_rreq  = 1'b0;
        bus.hist_addr  = '0;
        bus.hist_clear = 1'b0;
        case (state_r)
            ST_IDLE:  busy = 1'b0;
            ST_SWEEP: begin
                busy          = 1'b1;
                bus.hist_rreq = credit_s;
                bus.hist_addr = rd_addr_r;
            end
            ST_DRAIN: busy = 1'b1;
`ifdef HIST_AUTO_CLEAR_EN
            ST_CLR: begin
                busy           = 1'b1;
                bus.hist_clear = 1'b1;
            end
`endif
            ST_FIN:   done = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    // Sweep bookkeeping: read address, return index, running cdf and reads in flight
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rd_addr_r     <= '0;
            ret_bin_r     <= '0;
            cdf_acc_r     <= '0;
            outstanding_r <= '0;
        end else if (state_r == ST_IDLE) begin
            if (start) begin
                rd_addr_r     <= '0;
                ret_bin_r     <= '0;
                cdf_acc_r     <= '0;
                outstanding_r <= '0;
            end
        end else begin
            if (issue_s && !last_addr_s) rd_addr_r <= rd_addr_r + AW'(1'b1);
            if (accept_s) begin
                cdf_acc_r <= cdf_sum_s;
                ret_bin_r <= ret_bin_r + AW'(1'b1);
            end
            case ({issue_s, accept_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1'b1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1'b1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Output FIFO: returned beats are pushed in return order and popped on handshake
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
            for (int i = 32'sd0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= '0;
        end else begin
            if (accept_s) begin
                fifo_mem_r[wr_ptr_r] <= {ret_bin_r, bus.hist_data, cdf_sum_s};
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            case ({accept_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1'b1);
                2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1'b1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_histogram_reader.sv
// Directed bench for histogram_reader: a 4-bin instance with variable-latency RAM model and a full
// 256-bin instance (latency 3); expected beats/cdf are computed from the loaded counts.
module tb_histogram_reader;
    localparam int DW    = 19;
    localparam int CW    = 19;
    localparam int LAT_B = 3;
`ifdef HIST_AUTO_CLEAR_EN
    localparam int DONE_GAP = 3;
`else
    localparam int DONE_GAP = 2;
`endif

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic sel   = 1'b0;
    logic busy_a, done_a, busy_b, done_b;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt [256];
    logic [CW-1:0] last_cdf;

    always #5 clk = ~clk;

    histogram_reader_if #(.ADDRESS_WIDTH(2), .DATA_WIDTH(DW), .CDF_WIDTH(CW)) bus_a ();
    histogram_reader_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(DW), .CDF_WIDTH(CW)) bus_b ();

    histogram_reader #(.COLOR_RANGE(4), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .arstn(arstn), .start(start && !sel), .busy(busy_a), .done(done_a), .bus(bus_a));
    histogram_reader dut_b (
        .clk(clk), .arstn(arstn), .start(start && sel), .busy(busy_b), .done(done_b), .bus(bus_b));

    assign bus_a.out_ready = ready && !sel;
    assign bus_b.out_ready = ready && sel;

    // RAM model A: 4 bins, latency lat_a, data in issue order, clear zeroes all bins
    logic [DW-1:0] ram_a [4];
    logic [DW-1:0] load_a [4];
    logic          load_req_a = 1'b0;
    logic [7:0]    pv_a = 8'd0;
    logic [1:0]    pa_a [8];
    int            lat_a = 1;
    always @(posedge clk) begin
        pv_a    <= {pv_a[6:0], bus_a.hist_rreq};
        pa_a[0] <= bus_a.hist_addr;
        for (int i = 1; i < 8; i++) pa_a[i] <= pa_a[i-1];
        for (int i = 0; i < 4; i++) begin
            if (load_req_a) ram_a[i] <= load_a[i];
            else if (bus_a.hist_clear) ram_a[i] <= '0;
        end
    end
    assign bus_a.hist_dvalid = pv_a[lat_a-1];
    assign bus_a.hist_data   = bus_a.hist_dvalid ? ram_a[pa_a[lat_a-1]] : '0;

    // RAM model B: 256 bins, fixed latency LAT_B
    logic [DW-1:0] ram_b [256];
    logic [DW-1:0] load_b [256];
    logic          load_req_b = 1'b0;
    logic [7:0]    pv_b = 8'd0;
    logic [7:0]    pa_b [8];
    always @(posedge clk) begin
        pv_b    <= {pv_b[6:0], bus_b.hist_rreq};
        pa_b[0] <= bus_b.hist_addr;
        for (int i = 1; i < 8; i++) pa_b[i] <= pa_b[i-1];
        for (int i = 0; i < 256; i++) begin
            if (load_req_b) ram_b[i] <= load_b[i];
            else if (bus_b.hist_clear) ram_b[i] <= '0;
        end
    end
    assign bus_b.hist_dvalid = pv_b[LAT_B-1];
    assign bus_b.hist_data   = bus_b.hist_dvalid ? ram_b[pa_b[LAT_B-1]] : '0;

    wire          m_valid  = sel ? bus_b.out_valid : bus_a.out_valid;
    wire [7:0]    m_bin    = sel ? bus_b.out_bin : {6'd0, bus_a.out_bin};
    wire [DW-1:0] m_count  = sel ? bus_b.out_count : bus_a.out_count;
    wire [CW-1:0] m_cdf    = sel ? bus_b.out_cdf : bus_a.out_cdf;
    wire          m_rreq   = sel ? bus_b.hist_rreq : bus_a.hist_rreq;
    wire          m_dvalid = sel ? bus_b.hist_dvalid : bus_a.hist_dvalid;
    wire          m_clear  = sel ? bus_b.hist_clear : bus_a.hist_clear;
    wire          m_busy   = sel ? busy_b : busy_a;
    wire          m_done   = sel ? done_b : done_a;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_a4(input int c0, input int c1, input int c2, input int c3);
        load_a[0] = DW'(c0); load_a[1] = DW'(c1); load_a[2] = DW'(c2); load_a[3] = DW'(c3);
        exp_cnt[0] = c0; exp_cnt[1] = c1; exp_cnt[2] = c2; exp_cnt[3] = c3;
        load_req_a = 1'b1;
    endtask

    task automatic check_a_zero();
        check_value("rst_busy", busy_a, 0);
        check_value("rst_done", done_a, 0);
        check_value("rst_rreq", bus_a.hist_rreq, 0);
        check_value("rst_addr", bus_a.hist_addr, 0);
        check_value("rst_clear", bus_a.hist_clear, 0);
        check_value("rst_valid", bus_a.out_valid, 0);
        check_value("rst_bin", bus_a.out_bin, 0);
        check_value("rst_count", bus_a.out_count, 0);
        check_value("rst_cdf", bus_a.out_cdf, 0);
    endtask

    // Called at a negedge with the selected DUT idle; returns at the negedge one cycle after done.
    task automatic run_sweep(input int n_bins, input int rmode, input bit tput, input int restart_at,
                             input int max_cyc, output int max_cred);
        int     idx, first_cyc, last_cyc, done_cyc, clr_cyc, clr_n, outs, fcnt;
        longint exp_cdf;
        logic   rdy;
        idx = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; clr_cyc = -1; clr_n = 0;
        outs = 0; fcnt = 0; max_cred = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; load_req_a = 1'b0; load_req_b = 1'b0;
        check_value("busy_after_start", m_busy, 1);
        exp_cdf = exp_cnt[0];
        for (int cyc = 0; cyc < max_cyc && done_cyc < 0; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = (cyc == restart_at);
            rdy   = (rmode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            ready = rdy;
            if (m_rreq && (outs + fcnt + 1) > max_cred) max_cred = outs + fcnt + 1;
            if (m_valid) begin
                if (idx < n_bins) begin
                    check_value("beat_bin", m_bin, idx);
                    check_value("beat_count", m_count, exp_cnt[idx]);
                    check_value("beat_cdf", m_cdf, exp_cdf);
                    if (rdy) begin
                        if (first_cyc < 0) first_cyc = cyc;
                        last_cyc = cyc;
                        last_cdf = m_cdf;
                        idx++;
                        if (idx < n_bins) exp_cdf = exp_cdf + exp_cnt[idx];
                    end
                end else begin
                    check_value("extra_beat", idx, n_bins);
                end
            end
            if (m_clear) begin clr_n++; clr_cyc = cyc; end
            if (m_done) begin
                done_cyc = cyc;
                check_value("busy_at_done", m_busy, 0);
            end
            outs = outs + int'(m_rreq) - int'(m_dvalid);
            fcnt = fcnt + int'(m_dvalid) - int'(m_valid && rdy);
        end
        start = 1'b0;
        check_value("beat_total", idx, n_bins);
        check_value("done_seen", done_cyc >= 0, 1);
        check_value("done_after_last_beat", done_cyc - last_cyc, DONE_GAP);
`ifdef HIST_AUTO_CLEAR_EN
        check_value("clear_pulses", clr_n, 1);
        check_value("clear_slot", clr_cyc - last_cyc, 2);
`else
        check_value("clear_pulses", clr_n, 0);
`endif
        if (tput) check_value("beats_back_to_back", last_cyc - first_cyc, n_bins - 1);
        @(negedge clk);
        check_value("busy_after_done", m_busy, 0);
        check_value("done_one_cycle", m_done, 0);
    endtask

    initial begin
        int mc, outs, late;
        #1;
        check_a_zero();
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);

        // Basic sweep, latency 1, always ready
        load_a4(3, 0, 5, 8);
        run_sweep(4, 0, 1'b1, -1, 60, mc);
        check_value("credit_a_lat1", mc <= 4, 1);
        // Stalling consumer plus a start pulse mid-sweep that must be ignored
        load_a4(3, 0, 5, 8);
        run_sweep(4, 1, 1'b0, 2, 80, mc);
        check_value("credit_a_stall", mc <= 4, 1);
        // Start one cycle after done: cdf restarts at bin 0
        load_a4(7, 1, 0, 2);
        run_sweep(4, 0, 1'b1, -1, 60, mc);
        // Second sweep without reloading: zeros only when the reader cleared the histogram
`ifdef HIST_AUTO_CLEAR_EN
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
`endif
        run_sweep(4, 0, 1'b1, -1, 60, mc);

        // Reset with two reads in flight, latency 3
        lat_a = 3;
        repeat (10) @(negedge clk);
        load_a4(3, 0, 5, 8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; load_req_a = 1'b0;
        outs = 0;
        for (int k = 0; k < 20 && outs < 2; k++) begin
            outs = outs + int'(m_rreq) - int'(m_dvalid);
            @(negedge clk);
        end
        check_value("outstanding_before_reset", outs, 2);
        arstn = 1'b0;
        #1;
        check_a_zero();
        late = 0;
        @(negedge clk);
        late = late + int'(bus_a.hist_dvalid);
        arstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            late = late + int'(bus_a.hist_dvalid);
            check_value("late_dvalid_no_beat", bus_a.out_valid, 0);
            check_value("late_dvalid_idle", busy_a, 0);
        end
        check_value("late_dvalid_seen", late, 2);
        load_a4(3, 0, 5, 8);
        run_sweep(4, 0, 1'b0, -1, 60, mc);
        check_value("credit_a_lat3", mc <= 4, 1);

        // Full 640x480 frame over 256 bins, latency 3
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin load_b[i] = DW'(1200); exp_cnt[i] = 1200; end
        load_req_b = 1'b1;
        run_sweep(256, 0, 1'b0, -1, 3000, mc);
        check_value("cdf_bin255_full_frame", last_cdf, 307200);
        check_value("credit_b_ready", mc <= 4, 1);
        // Uneven counts with a stalling consumer: credit must saturate at exactly 4
        for (int i = 0; i < 256; i++) begin load_b[i] = DW'((i * 37) % 1500); exp_cnt[i] = (i * 37) % 1500; end
        load_req_b = 1'b1;
        run_sweep(256, 1, 1'b0, -1, 3000, mc);
        check_value("credit_b_stall_max", mc, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
